edff_bank_ctrl: RTL

EDFF_BANK_CTRL -- requirements
Module: edff_bank_ctrl

---
 rtl/edff_bank_ctrl_if.sv | 28 ++
 rtl/edff_bank_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/edff_bank_ctrl_if.sv
// Requester-side bus of the enable-flop bank controller.
// Master drives requests; slave is the controller.
interface edff_bank_ctrl_if #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int W    = 8,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ*AW-1:0] ADDR;
  logic [NREQ*W-1:0]  WD;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    ACK;
  logic               ERR;
  logic [NREG-1:0]    E;
  logic [W-1:0]       D;
  logic               BUSY;

  modport master (
    output REQ, ADDR, WD,
    input  GNT, ACK, ERR, E, D, BUSY
  );

  modport slave (
    input  REQ, ADDR, WD,
    output GNT, ACK, ERR, E, D, BUSY
  );
endinterface

// File: rtl/edff_bank_ctrl.sv
// Round-robin write controller for a bank of enable flops.
// Sequences setup / enable pulse / hold around each write.
module edff_bank_ctrl #(
  parameter int NREQ      = 4,
  parameter int NREG      = 8,
  parameter int W         = 8,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 2
) (
  input  logic          CK,
  input  logic          R,
  edff_bank_ctrl_if.slave bus
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (SETUP_CYC > HOLD_CYC) ?
                        SETUP_CYC : HOLD_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [AW-1:0]   addr_q;
  logic [W-1:0]    d_q;

  logic [PW-1:0]   win;
  logic            any;
  logic            in_range;
  logic            last_hold;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic [NREG-1:0] e;
  logic            err;
  int              idx;

  // Scan downward so the nearest requester after ptr wins last.
  always_comb begin
    win = ptr_q;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.REQ[idx]) begin
        win = PW'(idx);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && any) begin
        ptr_q  <= win;
        win_q  <= win;
        addr_q <= bus.ADDR[win*AW +: AW];
        d_q    <= bus.WD[win*W +: W];
      end
    end
  end

  assign in_range  = int'(addr_q) < NREG;
  assign last_hold = (state_q == HOLD) &&
                     (cnt_q == CW'(HOLD_CYC - 1));

  always_comb begin
    gnt = '0;
    ack = '0;
    e   = '0;
    err = 1'b0;
    if (state_q != IDLE) gnt[win_q] = 1'b1;
    if (state_q == WRITE && in_range)
      e = NREG'(1) << addr_q;
    if (last_hold) begin
      ack[win_q] = 1'b1;
      err        = !in_range;
    end
  end

  assign bus.GNT  = gnt;
  assign bus.ACK  = ack;
  assign bus.ERR  = err;
  assign bus.E    = e;
  assign bus.D    = d_q;
  assign bus.BUSY = (state_q != IDLE);
endmodule
